// File: rtl/keypad_if.sv
// Keypad pin and result bundle shared by the scanner and its consumer.
// master: scanner side (drives columns, reports keys); slave: keypad/consumer side.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_detected;
    logic       key_pulse;

    modport master (
        input  row,
        output col,
        output key,
        output key_detected,
        output key_pulse
    );

    modport slave (
        output row,
        input  col,
        input  key,
        input  key_detected,
        input  key_pulse
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with whole-scan debouncing and ghost rejection.
// Reports one committed key with a held flag and a one-cycle strobe on each new key.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        RAW_NONE,
        RAW_KEY,
        RAW_MULTI
    } raw_kind_e;

    logic [SW-1:0] slot_cnt;
    logic [1:0]    col_idx;

    raw_kind_e     acc_kind, last_kind, commit_kind, scan_kind;
    logic [3:0]    acc_code, last_code, commit_code, scan_code;

    logic [CW-1:0] cnt, cnt_next;
    logic          commit_pend;
    logic          sample, scan_end, same, commit;
    logic [3:0]    lows;
    logic          row_single;
    logic [1:0]    row_idx;

    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
        case ({c, r})
            4'h0:    key_code = 4'h1;
            4'h1:    key_code = 4'h4;
            4'h2:    key_code = 4'h7;
            4'h3:    key_code = 4'h0;
            4'h4:    key_code = 4'h2;
            4'h5:    key_code = 4'h5;
            4'h6:    key_code = 4'h8;
            4'h7:    key_code = 4'hF;
            4'h8:    key_code = 4'h3;
            4'h9:    key_code = 4'h6;
            4'hA:    key_code = 4'h9;
            4'hB:    key_code = 4'hE;
            4'hC:    key_code = 4'hA;
            4'hD:    key_code = 4'hB;
            4'hE:    key_code = 4'hC;
            default: key_code = 4'hD;
        endcase
    endfunction

    always_comb begin
        sample     = (slot_cnt == SLOT_LAST);
        scan_end   = sample && (col_idx == 2'd3);
        lows       = ~kp.row;
        row_single = (lows != 4'b0000) && ((lows & (lows - 4'd1)) == 4'b0000);

        case (lows)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase

        // A second low row anywhere in the scan, or several in one column, is MULTI.
        scan_kind = acc_kind;
        scan_code = acc_code;
        if (lows != 4'b0000) begin
            if (row_single && acc_kind == RAW_NONE) begin
                scan_kind = RAW_KEY;
                scan_code = key_code(col_idx, row_idx);
            end else begin
                scan_kind = RAW_MULTI;
                scan_code = '0;
            end
        end

        same = (scan_kind == last_kind) && (scan_code == last_code);
        if (same)
            cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
        else
            cnt_next = CW'(1);

        // Commit only on the scan where the counter first reaches the threshold.
        commit = (cnt_next == CNT_MAX) && !(same && (cnt == CNT_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt        <= '0;
            col_idx         <= 2'd0;
            kp.col          <= 4'b1110;
            acc_kind        <= RAW_NONE;
            acc_code        <= '0;
            last_kind       <= RAW_NONE;
            last_code       <= '0;
            cnt             <= '0;
            commit_pend     <= 1'b0;
            commit_kind     <= RAW_NONE;
            commit_code     <= '0;
            kp.key          <= '0;
            kp.key_detected <= 1'b0;
            kp.key_pulse    <= 1'b0;
        end else begin
            kp.key_pulse <= 1'b0;
            commit_pend  <= 1'b0;

            if (sample) begin
                slot_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                kp.col   <= {kp.col[2:0], kp.col[3]};
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end

            if (sample) begin
                if (scan_end) begin
                    acc_kind    <= RAW_NONE;
                    acc_code    <= '0;
                    last_kind   <= scan_kind;
                    last_code   <= scan_code;
                    cnt         <= cnt_next;
                    commit_pend <= commit;
                    commit_kind <= scan_kind;
                    commit_code <= scan_code;
                end else begin
                    acc_kind <= scan_kind;
                    acc_code <= scan_code;
                end
            end

            if (commit_pend) begin
                if (commit_kind == RAW_KEY) begin
                    kp.key          <= commit_code;
                    kp.key_detected <= 1'b1;
                    kp.key_pulse    <= !kp.key_detected || (kp.key != commit_code);
                end else begin
                    kp.key_detected <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 Pmod keypad on JA, debounces it and reports one stable key to the game FSM (`key`, `key_detected`, plus a one-cycle `key_pulse`). Sits directly upstream of the memorization game controller. Its outputs are registered, debounced and ghost-free, so the consumer only needs edge detection on `key_detected` or can use `key_pulse` directly.

## Interface
- `SCAN_CYCLES`, default 100000: clock cycles each column is driven (1 ms at 100 MHz); minimum 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to commit a result; minimum 1.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `row`  in  4  keypad rows (JA[7:4]); externally pulled up; low = pressed key in the driven column.
- `col`  out  4  keypad column drive (JA[3:0]); exactly one bit low at all times.
- `key`  out  4  committed key code; holds its last value after release.
- `key_detected`  out  1  high while a committed key is held.
- `key_pulse`  out  1  one-cycle strobe when a new key is committed.

## Operation
- **Column scan:**
  - Column index c cycles 0→1→2→3→0.
  - During slot c, `col[c]=0` and all other `col` bits are 1.
  - Each slot lasts `SCAN_CYCLES` cycles.
  - Rows are sampled only in the last cycle of the slot (cycle `SCAN_CYCLES-1`), which gives settling time.
- **Key map (c, row bit r low):**
  - c0: r0..r3 = 1, 4, 7, 0.
  - c1: r0..r3 = 2, 5, 8, F.
  - c2: r0..r3 = 3, 6, 9, E.
  - c3: r0..r3 = A, B, C, D.
- **Raw scan result:** built over the four samples as one of NONE, a single key code, or MULTI.
  - Zero low rows across the scan → NONE.
  - Exactly one low row in exactly one column → that key.
  - Anything more → MULTI. MULTI is treated as NONE for commit (ghost rejection).
- **Debounce (at each scan end):**
  - If raw == last_raw: `cnt <= min(cnt+1, DEBOUNCE_SCANS)`.
  - Otherwise: `cnt <= 1`.
  - In both cases `last_raw <= raw`.
  - A commit occurs when the updated `cnt` first equals `DEBOUNCE_SCANS`. Saturation prevents repeated commits.
- **Commit:**
  - Key k: `key <= k`, `key_detected <= 1`. `key_pulse` fires if the previous committed state was NONE or a different key.
  - NONE/MULTI: `key_detected <= 0`; `key` unchanged; no pulse.
  - Key-to-key change (k1→k2 without an intervening NONE commit): `key_detected` stays 1, `key` changes, and one pulse fires.

## Timing
- **Reset values:**
  - `col = 4'b1110` (c=0, slot cycle 0).
  - `key = 0`, `key_detected = 0`, `key_pulse = 0`.
  - `cnt = 0`, `last_raw = NONE`, committed state NONE.
- **Scan period:** `4*SCAN_CYCLES` cycles. The `col` change takes effect at the edge after the slot's sample cycle.
- **Scan end:** the sample cycle of c3. The raw result and debounce counter update at that edge.
- **Output latency:** `key`, `key_detected` and `key_pulse` update one clock after the scan-end edge. `key_pulse` is high for exactly that one cycle.
- **Press latency:** a press stable before a scan begins is committed after `DEBOUNCE_SCANS` full scans plus 1 cycle.
- **Release latency:** `key_detected` falls with the same latency.
- **Sampling:** row changes outside sample cycles are ignored. A press shorter than one scan may be missed (by design).
- **Reset mid-operation:** any cycle, including mid-slot or mid-commit. The next cycle shows reset values and scanning restarts at c0, slot cycle 0. No pulse is generated by the reset.
- **Width rules:** `cnt` uses `clog2(DEBOUNCE_SCANS+1)` bits. The slot counter uses `clog2(SCAN_CYCLES)` bits and wraps to 0 after `SCAN_CYCLES-1`.

## Test plan
Bench parameters: `SCAN_CYCLES=4`, `DEBOUNCE_SCANS=3` (scan = 16 cycles). The keypad model drives `row[r]=0` whenever the pressed key's column is low.

1. **Reset, no keys:** release reset with no key pressed → `col` sequence is 1110 x4, 1101 x4, 1011 x4, 0111 x4 with period 16. Over 200 cycles, `key=0`, `key_detected=0` and `key_pulse` never asserts.
2. **Single press and release:** hold '5' (c1, r1) from cycle 0 after reset → `key=5`, `key_detected=1` and a single 1-cycle `key_pulse` at cycle 48+1. On release → `key_detected=0` 3 scans + 1 cycle later, `key` stays 5, no pulse.
3. **Bounce rejection:** toggle '7' every 10 cycles for 120 cycles, then hold → no `key_detected` during bouncing. Exactly one pulse with `key=7` after 3 stable scans.
4. **Ghost rejection:** hold '1' and '2' together → never detected. Then hold only 'F' → `key=4'hF`, `key_detected=1`, one pulse.
5. **Key-to-key change:** hold '3', then switch directly to '9' with no gap → `key_detected` stays 1 throughout, `key` goes 3→9, and a second pulse fires on the 9 commit.
6. **Reset mid-press:** assert `rst` for 1 cycle while 'A' is committed and held → next cycle `key=0`, `key_detected=0`, `col=1110`. `key_detected` re-asserts 48+1 cycles after reset deasserts, with a fresh pulse.
